// File: rtl/stack_alu_sequencer.sv
// Clocked sequencer for a stack-based ALU: pops operands, drives the ALU, captures the
// result and flags, pushes the result back, and guards the stack depth.
module stack_alu_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       instr_valid,
   output logic                       instr_ready,
   input  logic [1:0]                 inst_code,
   input  logic [2:0]                 op_code,
   input  logic [WIDTH-1:0]           imm,
   input  logic [WIDTH-1:0]           stack_top,
   output logic                       stack_push,
   output logic                       stack_pop,
   output logic [WIDTH-1:0]           stack_wdata,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [1:0]                 selector,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic [2:0]                 alu_flags,
   output logic [2:0]                 flags,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       busy,
   output logic                       err,
   output logic [1:0]                 err_code,
   input  logic                       err_clr
);

   localparam int DW = $clog2(DEPTH+1);
   localparam logic [DW-1:0] FULL = DW'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_POP_A, S_POP_B, S_EXEC, S_PUSH, S_ERR} state_t;
   typedef enum logic [1:0] {I_NOP = 2'b00, I_PUSH = 2'b01, I_ALU = 2'b10, I_POP = 2'b11} inst_t;

   state_t           r_state;
   logic             r_is_pop;
   logic             r_is_unary;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_sel;
   logic [2:0]       r_flags;
   logic [DW-1:0]    r_depth;
   logic             r_err;
   logic [1:0]       r_err_code;

   logic             w_unary;
   logic [1:0]       w_alu_sel;
   logic             w_alu_short;

   assign w_unary     = (op_code == 3'b100) || (op_code == 3'b111);
   assign w_alu_sel   = (op_code == 3'b100) ? 2'b10 :
                        (op_code == 3'b111) ? 2'b11 : 2'b01;
   // Underflow check uses the depth seen before this instruction is accepted.
   assign w_alu_short = w_unary ? (r_depth == '0) : (r_depth < DW'(2));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_is_pop   <= 1'b0;
         r_is_unary <= 1'b0;
         r_wdata    <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_sel      <= 2'b00;
         r_flags    <= 3'b000;
         r_depth    <= '0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every register in this block sees pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_sel      <= (inst_t'(inst_code) == I_ALU) ? w_alu_sel : 2'b00;
                  r_is_pop   <= (inst_t'(inst_code) == I_POP);
                  r_is_unary <= w_unary;
                  case (inst_t'(inst_code))
                     I_NOP: r_state <= S_IDLE;
                     I_PUSH: begin
                        if (r_depth == FULL) begin
                           r_state    <= S_ERR;
                           r_err      <= 1'b1;
                           r_err_code <= 2'b01;
                        end else begin
                           r_wdata <= imm;
                           r_state <= S_PUSH;
                        end
                     end
                     I_POP: begin
                        if (r_depth == '0) begin
                           r_state    <= S_ERR;
                           r_err      <= 1'b1;
                           r_err_code <= 2'b10;
                        end else begin
                           r_state <= S_POP_A;
                        end
                     end
                     I_ALU: begin
                        if (w_alu_short) begin
                           r_state    <= S_ERR;
                           r_err      <= 1'b1;
                           r_err_code <= 2'b10;
                        end else begin
                           r_state <= S_POP_A;
                        end
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_POP_A: begin
               r_a     <= stack_top;
               r_depth <= r_depth - DW'(1);
               if (r_is_pop)        r_state <= S_IDLE;
               else if (r_is_unary) r_state <= S_EXEC;
               else                 r_state <= S_POP_B;
            end
            S_POP_B: begin
               // First popped value becomes operand b.
               r_b     <= r_a;
               r_a     <= stack_top;
               r_depth <= r_depth - DW'(1);
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_wdata <= alu_result;
               r_flags <= alu_flags;
               r_state <= S_PUSH;
            end
            S_PUSH: begin
               r_depth <= r_depth + DW'(1);
               r_state <= S_IDLE;
            end
            S_ERR: begin
               if (err_clr) begin
                  r_err      <= 1'b0;
                  r_err_code <= 2'b00;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign instr_ready = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign stack_pop   = (r_state == S_POP_A) || (r_state == S_POP_B);
   assign stack_push  = (r_state == S_PUSH);
   assign stack_wdata = r_wdata;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign selector    = r_sel;
   assign flags       = r_flags;
   assign depth       = r_depth;
   assign err         = r_err;
   assign err_code    = r_err_code;

endmodule
